// File: rtl/iob_cache_writeback_channel.sv
// -----------------------------------------------------------------------------
// iob_cache_writeback_channel
//
// Purpose:
//   Takes one dirty cache line and writes it to the backend memory one word
//   at a time. It addresses words from word 0 up to the last word of the line.
//   A one-cycle wb_done pulse follows the last accepted word, and then the
//   channel is ready for a new line.
//
// Ports:
//   clk_i     - sole clock; all state updates on its rising edge
//   reset     - synchronous, active-high reset
//   wb_valid  - write-back request from the cache
//   wb_addr   - line address (byte address bits above the word/line offset)
//   wb_line   - line data, word k at [k*BE_DATA_W +: BE_DATA_W]
//   wb_ready  - high only while idle; request taken on wb_valid && wb_ready
//   wb_done   - one-cycle pulse after the last word has been accepted
//   be_valid  - backend write request
//   be_addr   - backend byte address
//   be_wdata  - backend write data
//   be_wstrb  - backend byte enables (all ones while writing, zero otherwise)
//   be_ready  - backend accepts the current word this cycle
// -----------------------------------------------------------------------------
module iob_cache_writeback_channel #(
    parameter int ADDR_W     = 32,
    parameter int BE_ADDR_W  = 32,
    parameter int BE_DATA_W  = 32,
    parameter int LINE2BE_W  = 2,
    localparam int BE_NBYTES_W = $clog2(BE_DATA_W / 8),
    localparam int NWORDS      = 2 ** LINE2BE_W,
    localparam int LINE_ADDR_W = ADDR_W - BE_NBYTES_W - LINE2BE_W
) (
    input  logic                          clk_i,
    input  logic                          reset,
    input  logic                          wb_valid,
    input  logic [LINE_ADDR_W-1:0]        wb_addr,
    input  logic [NWORDS*BE_DATA_W-1:0]   wb_line,
    output logic                          wb_ready,
    output logic                          wb_done,
    output logic                          be_valid,
    output logic [BE_ADDR_W-1:0]          be_addr,
    output logic [BE_DATA_W-1:0]          be_wdata,
    output logic [BE_DATA_W/8-1:0]        be_wstrb,
    input  logic                          be_ready
);

    // The counter keeps at least one bit so that a single-word line still has
    // a legal register; in that case it simply stays at zero.
    localparam int CNT_W = (LINE2BE_W > 0) ? LINE2BE_W : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                        r_state;
    logic [CNT_W-1:0]              r_cnt;
    logic [LINE_ADDR_W-1:0]        r_line_addr;
    logic [NWORDS*BE_DATA_W-1:0]   r_line;
    logic                          r_wb_ready;
    logic                          r_wb_done;
    logic                          r_be_valid;

    logic [ADDR_W-1:0]             w_byte_addr;
    logic [BE_DATA_W-1:0]          w_wdata;

    // Control FSM. The handshake outputs are registered alongside the state
    // so each one changes exactly on the edge that moves the FSM. The line
    // address and data are captured only when a request is accepted, so the
    // cache may change its inputs freely while a transfer is in progress.
    // Reset returns the FSM to idle and drops any partial transfer. The
    // line buffer is left alone because it is reloaded on every acceptance.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_wb_ready <= 1'b1;
            r_wb_done  <= 1'b0;
            r_be_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (wb_valid) begin
                        r_line_addr <= wb_addr;
                        r_line      <= wb_line;
                        r_cnt       <= '0;
                        r_state     <= WRITE;
                        r_wb_ready  <= 1'b0;
                        r_be_valid  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (be_ready) begin
                        if (r_cnt == LAST_CNT) begin
                            r_state    <= DONE;
                            r_be_valid <= 1'b0;
                            r_wb_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_wb_done  <= 1'b0;
                    r_wb_ready <= 1'b1;
                end
                default: begin
                    r_state    <= IDLE;
                    r_wb_done  <= 1'b0;
                    r_wb_ready <= 1'b1;
                    r_be_valid <= 1'b0;
                end
            endcase
        end
    end

    // Address and data of the current word. A single-word line has no word
    // index field. In that case the line buffer is the whole word.
    generate
        if (LINE2BE_W > 0) begin : g_multi_word
            assign w_byte_addr = (ADDR_W'(r_line_addr) << (BE_NBYTES_W + LINE2BE_W))
                               | (ADDR_W'(r_cnt) << BE_NBYTES_W);
            assign w_wdata     = r_line[r_cnt*BE_DATA_W +: BE_DATA_W];
        end else begin : g_single_word
            assign w_byte_addr = ADDR_W'(r_line_addr) << BE_NBYTES_W;
            assign w_wdata     = r_line;
        end
    endgenerate

    // Output drive. Both the address and the data come from registers, so
    // they hold steady across backpressure without any extra logic.
    assign wb_ready = r_wb_ready;
    assign wb_done  = r_wb_done;
    assign be_valid = r_be_valid;
    assign be_addr  = BE_ADDR_W'(w_byte_addr);
    assign be_wdata = w_wdata;
    assign be_wstrb = {(BE_DATA_W/8){r_be_valid}};

endmodule

// File: tb/tb_iob_cache_writeback_channel.sv
// -----------------------------------------------------------------------------
// tb_iob_cache_writeback_channel
//
// Purpose:
//   Self-checking bench for iob_cache_writeback_channel.
//   - Main instance: 4 words per line. A predictor turns every accepted
//     request into a queue of expected backend beats and tracks when the
//     channel should be busy, done or idle. A separate monitor compares the
//     DUT against it every cycle.
//   - Second instance: one word per line. It is checked with directed
//     expectations.
// -----------------------------------------------------------------------------
module tb_iob_cache_writeback_channel;

    localparam int ADDR_W    = 32;
    localparam int BE_DATA_W = 32;
    localparam int NW        = 4;
    localparam int LAW       = 28;
    localparam int LAW0      = 30;

    logic           clk = 1'b0;
    logic           reset = 1'b1;

    logic           wbValid = 1'b0;
    logic [LAW-1:0] wbAddr = '0;
    logic [127:0]   wbLine = '0;
    logic           wbReady;
    logic           wbDone;
    logic           beValid;
    logic [31:0]    beAddr;
    logic [31:0]    beWdata;
    logic [3:0]     beWstrb;
    logic           beReady = 1'b0;

    logic            wbValid0 = 1'b0;
    logic [LAW0-1:0] wbAddr0 = '0;
    logic [31:0]     wbLine0 = '0;
    logic            wbReady0;
    logic            wbDone0;
    logic            beValid0;
    logic [31:0]     beAddr0;
    logic [31:0]     beWdata0;
    logic [3:0]      beWstrb0;
    logic            beReady0 = 1'b0;

    always #5 clk = ~clk;

    iob_cache_writeback_channel #(
        .ADDR_W(ADDR_W), .BE_ADDR_W(32), .BE_DATA_W(BE_DATA_W), .LINE2BE_W(2)
    ) dut (
        .clk_i(clk), .reset(reset),
        .wb_valid(wbValid), .wb_addr(wbAddr), .wb_line(wbLine),
        .wb_ready(wbReady), .wb_done(wbDone),
        .be_valid(beValid), .be_addr(beAddr), .be_wdata(beWdata),
        .be_wstrb(beWstrb), .be_ready(beReady)
    );

    iob_cache_writeback_channel #(
        .ADDR_W(ADDR_W), .BE_ADDR_W(32), .BE_DATA_W(BE_DATA_W), .LINE2BE_W(0)
    ) dut0 (
        .clk_i(clk), .reset(reset),
        .wb_valid(wbValid0), .wb_addr(wbAddr0), .wb_line(wbLine0),
        .wb_ready(wbReady0), .wb_done(wbDone0),
        .be_valid(beValid0), .be_addr(beAddr0), .be_wdata(beWdata0),
        .be_wstrb(beWstrb0), .be_ready(beReady0)
    );

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Reference model: expected beats plus words left, done pending and idle
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t expQ[$];
    int    mRemain   = 0;
    bit    mDonePend = 1'b0;
    bit    mIdle     = 1'b1;
    bit    modelLive = 1'b0;
    int    doneSeen  = 0;

    // Predictor: applies each clock edge to the model using the inputs the
    // bench drove before that edge
    always @(posedge clk) begin : predictor
        beat_t b;
        if (reset) begin
            expQ.delete();
            mRemain   = 0;
            mDonePend = 1'b0;
            mIdle     = 1'b1;
            modelLive = 1'b1;
        end else if (modelLive) begin
            if (mIdle) begin
                if (wbValid) begin
                    for (int k = 0; k < NW; k++) begin
                        b.addr = (32'(wbAddr) * 32'(NW) + 32'(k)) * 32'd4;
                        b.data = wbLine[k*32 +: 32];
                        expQ.push_back(b);
                    end
                    mRemain = NW;
                    mIdle   = 1'b0;
                end
            end else if (mRemain > 0) begin
                if (beReady) begin
                    mRemain--;
                    if (mRemain == 0) mDonePend = 1'b1;
                end
            end else if (mDonePend) begin
                mDonePend = 1'b0;
                mIdle     = 1'b1;
            end
        end
    end

    // Monitor: compares the DUT against the model mid-cycle, pops one beat
    // per backend handshake, and checks that a stalled word stays stable
    logic        holdPrev = 1'b0;
    logic [31:0] prevAddr = '0;
    logic [31:0] prevData = '0;

    always @(negedge clk) begin : monitor
        beat_t got;
        if (modelLive) begin
            checkOutput("wb_ready", 64'(wbReady), 64'(mIdle));
            checkOutput("wb_done", 64'(wbDone), 64'(mDonePend));
            checkOutput("be_valid", 64'(beValid), 64'(mRemain > 0));
            checkOutput("be_wstrb", 64'(beWstrb), (mRemain > 0) ? 64'hF : 64'h0);
            if (wbDone) doneSeen++;
            if (holdPrev) begin
                checkOutput("hold_addr", 64'(beAddr), 64'(prevAddr));
                checkOutput("hold_data", 64'(beWdata), 64'(prevData));
            end
            if (beValid && beReady && !reset) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got addr 0x%0h, expected no beat at %0t",
                             beAddr, $time);
                end else begin
                    got = expQ.pop_front();
                    checkOutput("beat_addr", 64'(beAddr), 64'(got.addr));
                    checkOutput("beat_data", 64'(beWdata), 64'(got.data));
                end
            end
            holdPrev = beValid && !beReady && !reset;
            prevAddr = beAddr;
            prevData = beWdata;
        end
    end

    // Backend ready driver: either a fixed level from the scenario or random
    logic forcedReady = 1'b1;
    logic randomReady = 1'b0;

    always @(posedge clk) begin : readyDriver
        #2;
        beReady = randomReady ? ($urandom_range(0, 3) != 0) : forcedReady;
    end

    task automatic waitIdle();
        int n = 0;
        while (!mIdle && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!mIdle) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got busy, expected idle within 300 cycles");
        end
    endtask

    // Presents one request in an idle cycle, then scrambles the inputs so
    // that only the values captured at acceptance can reach the backend
    task automatic applyStimulus(input logic [LAW-1:0] a, input logic [127:0] line);
        waitIdle();
        wbValid = 1'b1;
        wbAddr  = a;
        wbLine  = line;
        @(posedge clk);
        #1;
        wbValid = 1'b0;
        wbAddr  = LAW'($urandom);
        wbLine  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int d0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_wb_ready0", 64'(wbReady0), 64'h1);
        checkOutput("reset_be_wstrb0", 64'(beWstrb0), 64'h0);

        // Plain burst with the backend always ready
        forcedReady = 1'b1;
        d0 = doneSeen;
        applyStimulus(28'h0400000, {32'h44, 32'h33, 32'h22, 32'h11});
        waitIdle();
        checkOutput("burst_done_count", 64'(doneSeen - d0), 64'h1);

        // Backend stalls for three cycles on word 2
        d0 = doneSeen;
        applyStimulus(28'h0ABCDE0, {32'hD4, 32'hC3, 32'hB2, 32'hA1});
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        forcedReady = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        forcedReady = 1'b1;
        waitIdle();
        checkOutput("bp_done_count", 64'(doneSeen - d0), 64'h1);

        // A second request while busy must be ignored
        d0 = doneSeen;
        applyStimulus(28'h0000010, {32'h4444, 32'h3333, 32'h2222, 32'h1111});
        @(posedge clk);
        #1;
        wbValid = 1'b1;
        wbAddr  = 28'h0FFFFF0;
        wbLine  = {4{32'hDEADBEEF}};
        @(posedge clk);
        #1;
        wbValid = 1'b0;
        waitIdle();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("busy_done_count", 64'(doneSeen - d0), 64'h1);

        // Reset while word 2 is pending, then a fresh request
        d0 = doneSeen;
        applyStimulus(28'h0123450, {32'hA4, 32'hA3, 32'hA2, 32'hA1});
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("reset_done_count", 64'(doneSeen - d0), 64'h0);
        d0 = doneSeen;
        applyStimulus(28'h0222220, {32'hB4, 32'hB3, 32'hB2, 32'hB1});
        waitIdle();
        checkOutput("restart_done_count", 64'(doneSeen - d0), 64'h1);

        // Random lines with random backpressure and stray busy requests
        randomReady = 1'b1;
        d0 = doneSeen;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(LAW'($urandom), {$urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(0, 2) == 0) begin
                wbValid = 1'b1;
                @(posedge clk);
                #1;
                wbValid = 1'b0;
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        waitIdle();
        randomReady = 1'b0;
        forcedReady = 1'b1;
        checkOutput("random_done_count", 64'(doneSeen - d0), 64'd25);

        // Single-word line: backend always ready
        beReady0 = 1'b1;
        wbValid0 = 1'b1;
        wbAddr0  = LAW0'(32'h12345678 >> 2);
        wbLine0  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        wbValid0 = 1'b0;
        wbLine0  = 32'h0;
        checkOutput("w0_be_valid", 64'(beValid0), 64'h1);
        checkOutput("w0_be_addr", 64'(beAddr0), 64'h12345678);
        checkOutput("w0_be_wdata", 64'(beWdata0), 64'hCAFEF00D);
        checkOutput("w0_be_wstrb", 64'(beWstrb0), 64'hF);
        checkOutput("w0_wb_ready", 64'(wbReady0), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("w0_wb_done", 64'(wbDone0), 64'h1);
        checkOutput("w0_be_valid_off", 64'(beValid0), 64'h0);
        checkOutput("w0_be_wstrb_off", 64'(beWstrb0), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("w0_ready_again", 64'(wbReady0), 64'h1);
        checkOutput("w0_done_cleared", 64'(wbDone0), 64'h0);

        // Single-word line: backend stalls one cycle, top address
        beReady0 = 1'b0;
        wbValid0 = 1'b1;
        wbAddr0  = 30'h3FFFFFFF;
        wbLine0  = 32'h5A5A1234;
        @(posedge clk);
        #1;
        wbValid0 = 1'b0;
        checkOutput("w0s_be_addr", 64'(beAddr0), 64'hFFFFFFFC);
        @(posedge clk);
        #1;
        checkOutput("w0s_still_valid", 64'(beValid0), 64'h1);
        checkOutput("w0s_be_wdata", 64'(beWdata0), 64'h5A5A1234);
        checkOutput("w0s_no_done", 64'(wbDone0), 64'h0);
        beReady0 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("w0s_wb_done", 64'(wbDone0), 64'h1);
        beReady0 = 1'b0;

        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checkOutput("queue_drained", 64'(expQ.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
